led_matrix_tx: RTL and testbench
================================

# led_matrix_tx

Host-side serializer for the LED matrix driver's three-wire load interface (din, dclk, strobe). Accepts parallel words over a valid/ready handshake and shifts them out MSB-first with a programmable bit rate. Optionally pulses strobe after a word to latch the receiver's shift register. Sits in the test/host harness and in any on-chip pattern generator that feeds the matrix driver.

## Interface

Parameters:
- DATA_W, 16, bits per word shifted out; minimum 1.
- DIV, 4, clk cycles per dclk half-period; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  enable; low freezes the block.
- data  input  DATA_W  word to send; captured on accept.
- latch  input  1  captured with data; 1 = pulse strobe after this word.
- valid  input  1  word offered.
- ready  output  1  block can accept a word.
- din  output  1  serial data to the receiver.
- dclk  output  1  serial clock; receiver samples din on the rising edge.
- strobe  output  1  latch pulse to the receiver.
- busy  output  1  transfer in progress (state not IDLE).

## Operation

- States: IDLE, LOW, HIGH, STROB.
- IDLE: ready = ena; dclk = 0, strobe = 0, din = 0. Accept when valid && ready. Capture data into the shift register and latch into a flag. Load bit counter = DATA_W-1 and phase counter = DIV-1. Go to LOW.
- LOW: dclk = 0, din = shift[DATA_W-1]. Stay DIV cycles, then go to HIGH with phase counter reloaded.
- HIGH: dclk = 1, din unchanged. Stay DIV cycles. At the end of the phase:
  - bit counter ≠ 0: shift left by 1, decrement bit counter, go to LOW.
  - bit counter = 0 and latch flag set: go to STROB.
  - bit counter = 0 and latch flag clear: go to IDLE.
- STROB: strobe = 1, dclk = 0, din = 0. Stay DIV cycles, then go to IDLE.
- Phase counter width is $clog2(DIV)+1 and bit counter width is $clog2(DATA_W)+1, both unsigned. The phase counter reloads to DIV-1 on every state entry, and a state exits when the counter reaches 0.
- ready is 0 in every state except IDLE. Words are never queued. valid asserted during a transfer is ignored until the block returns to IDLE.
- data and latch are sampled only in the accept cycle. Later changes have no effect on the transfer in flight.
- ena low: all state, counters and outputs hold their values, and ready = 0. Transfer resumes where it stopped when ena returns high.
- Reset asserted at any time, including mid-word: state returns to IDLE immediately (asynchronously). din, dclk, strobe, busy and the shift register clear to 0. The partial word is discarded; the receiver sees no strobe.
- Reset values: din 0, dclk 0, strobe 0, busy 0, ready 0 while rst_n low, then ready = ena.

## Timing

Accept occurs in cycle 0 (clock edge where valid && ready).
- din valid from cycle 1. For bit i (i = 0 is the MSB):
  - LOW phase: cycles 1+2·DIV·i … DIV+2·DIV·i.
  - HIGH phase: cycles 1+DIV+2·DIV·i … 2·DIV+2·DIV·i.
- Setup and hold to each dclk rising edge are DIV cycles each.
- Last HIGH phase ends at cycle 2·DIV·DATA_W.
- latch = 1: strobe high for cycles 1+2·DIV·DATA_W … DIV+2·DIV·DATA_W. ready = 1 again at cycle 1+2·DIV·DATA_W+DIV.
- latch = 0: ready = 1 at cycle 1+2·DIV·DATA_W.
- busy = 1 from cycle 1 until the cycle before ready returns.
- With valid held high, back-to-back words are accepted in the first IDLE cycle. There is exactly one IDLE cycle between words (dclk low, din 0).
- Total cycles through the ena-low intervals are extended one-for-one by the stall; no other effect.

## Test plan

Bench configuration unless stated: DATA_W=8, DIV=2.

1. **Reset:** hold rst_n low for 3 cycles with valid=1 → din=dclk=strobe=busy=ready=0; no accept occurs.
2. **Single word with latch:** send 0xA5 with latch=1 → din sampled at 8 dclk rising edges reads 1,0,1,0,0,1,0,1. dclk rises at cycles 3,7,…,31. strobe is high in cycles 33–34. ready returns at cycle 35.
3. **Back-to-back without latch:** send 0xFF then 0x01 with latch=0 and valid held → second accept at cycle 33; 16 rising edges total; strobe never asserts.
4. **ena stall:** drop ena for 5 cycles starting at cycle 10 of a 0x3C transfer → all outputs frozen during the stall. Bit sequence is 0,0,1,1,1,1,0,0. strobe shifts 5 cycles later, to cycles 38–39.
5. **Reset mid-word:** assert rst_n low at cycle 12 of a 0x81 latch=1 transfer → outputs are 0 in the same cycle. No strobe occurs. After release, a new word 0x42 is sent correctly.
6. **DIV=1 corner:** rebuild with DIV=1, DATA_W=1, and send 1 with latch=1 → din=1 at cycle 1, dclk high at cycle 2, strobe high at cycle 3, ready at cycle 4.

Source files
------------

// File: rtl/led_matrix_tx_if.sv
// Word handshake between a producer and the LED matrix serializer.
// The producer offers data/latch with valid; the serializer answers with ready.
interface led_matrix_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              latch;
    logic              valid;
    logic              ready;

    modport master (output data, output latch, output valid, input ready);
    modport slave  (input data, input latch, input valid, output ready);
endinterface

// File: rtl/led_matrix_tx.sv
// Serializer for the LED matrix driver load interface (din, dclk, strobe).
// Words are shifted out MSB-first; each bit spends DIV cycles with dclk low
// (setup) and DIV cycles with dclk high (hold). An optional strobe pulse of
// DIV cycles follows the last bit to latch the receiver's shift register.
module led_matrix_tx #(
    parameter int DATA_W = 16,
    parameter int DIV    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    led_matrix_tx_if.slave   bus,
    output logic             din,
    output logic             dclk,
    output logic             strobe,
    output logic             busy
);
    localparam int PH_W  = $clog2(DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, STROB} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_d;
    logic [BIT_W-1:0]    bit_q;
    logic [PH_W-1:0]     phase_q;
    logic                latch_flag_q;
    logic                din_q;
    logic                dclk_q;
    logic                strobe_q;

    // Next shift register contents when advancing to the following bit.
    assign shift_d = shift_q << 1;

    // NOTE: ready is combinational so it drops in the same cycle ena or rst_n
    // goes low; it only depends on registered state plus those two inputs.
    assign bus.ready = rst_n && ena && (state_q == IDLE);

    assign din    = din_q;
    assign dclk   = dclk_q;
    assign strobe = strobe_q;
    assign busy   = (state_q != IDLE);

    // Transfer FSM with registered serial outputs; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_q        <= '0;
            phase_q      <= '0;
            latch_flag_q <= 1'b0;
            din_q        <= 1'b0;
            dclk_q       <= 1'b0;
            strobe_q     <= 1'b0;
        end else if (ena) begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of state and counters.
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        shift_q      <= bus.data;
                        latch_flag_q <= bus.latch;
                        bit_q        <= BIT_LOAD;
                        phase_q      <= PH_LOAD;
                        din_q        <= bus.data[DATA_W-1];
                        state_q      <= LOW;
                    end
                end
                LOW: begin
                    if (phase_q == '0) begin
                        phase_q <= PH_LOAD;
                        dclk_q  <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                    end
                end
                HIGH: begin
                    if (phase_q == '0) begin
                        phase_q <= PH_LOAD;
                        dclk_q  <= 1'b0;
                        if (bit_q != '0) begin
                            shift_q <= shift_d;
                            bit_q   <= bit_q - BIT_W'(1);
                            din_q   <= shift_d[DATA_W-1];
                            state_q <= LOW;
                        end else if (latch_flag_q) begin
                            din_q    <= 1'b0;
                            strobe_q <= 1'b1;
                            state_q  <= STROB;
                        end else begin
                            din_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                    end
                end
                STROB: begin
                    if (phase_q == '0) begin
                        strobe_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_matrix_tx.sv
// Directed bench for led_matrix_tx: DATA_W=8/DIV=2 main instance plus a
// DATA_W=1/DIV=1 corner instance. Cycle n+1 is the period after the edge
// that ends cycle n; the accept edge ends cycle 0.
module tb_led_matrix_tx;
    localparam int DW = 8;
    localparam int DV = 2;

    logic clk;
    logic rst_n;
    logic ena;
    logic din, dclk, strobe, busy;
    logic din2, dclk2, strobe2, busy2;

    int errors = 0;
    int checks = 0;
    int total_rises = 0;
    int total_strobes = 0;

    led_matrix_tx_if #(.DATA_W(DW)) bus ();
    led_matrix_tx_if #(.DATA_W(1))  bus2 ();

    led_matrix_tx #(.DATA_W(DW), .DIV(DV)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus.slave),
        .din(din), .dclk(dclk), .strobe(strobe), .busy(busy)
    );

    led_matrix_tx #(.DATA_W(1), .DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus2.slave),
        .din(din2), .dclk(dclk2), .strobe(strobe2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, then check {din,dclk,strobe,busy,ready} every cycle
    // until the first cycle ready is back. ena is dropped for len cycles
    // starting at cycle s (len=0: no stall). keep leaves valid high with
    // junk data during the transfer so the next word can follow directly.
    task automatic xfer(input string name, input logic [DW-1:0] w, input logic l,
                        input int s, input int len, input logic keep);
        int base;
        int last;
        int eff;
        int rises;
        int strobes;
        logic prev_dclk;
        logic [DW-1:0] got;
        logic [4:0] e;
        base = 2 * DV * DW;
        last = base + (l ? DV : 0) + len + 1;
        rises = 0;
        strobes = 0;
        prev_dclk = 1'b0;
        got = '0;
        ena = 1'b1;
        bus.data = w;
        bus.latch = l;
        bus.valid = 1'b1;
        #1;
        check($sformatf("%s accept_ready", name), 32'(bus.ready), 32'd1);
        tick();
        bus.valid = keep;
        bus.data = ~w;
        bus.latch = ~l;
        for (int c = 1; c <= last; c++) begin
            ena = !(len > 0 && c >= s && c < s + len);
            #1;
            if (len == 0 || c < s) eff = c;
            else if (c <= s + len) eff = s;
            else eff = c - len;
            if (eff <= base) begin
                e = {w[DW-1-((eff-1)/(2*DV))], ((eff-1) % (2*DV)) >= DV, 1'b0, 1'b1, 1'b0};
            end else if (l && eff <= base + DV) begin
                e = 5'b00110;
            end else begin
                e = {4'b0000, ena};
            end
            check($sformatf("%s c%0d {din,dclk,strobe,busy,ready}", name, c),
                  32'({din, dclk, strobe, busy, bus.ready}), 32'(e));
            if (dclk && !prev_dclk) begin
                rises++;
                got = {got[DW-2:0], din};
            end
            prev_dclk = dclk;
            if (strobe) strobes++;
            if (c < last) tick();
        end
        check($sformatf("%s rising_edges", name), 32'(rises), 32'(DW));
        check($sformatf("%s sampled_word", name), 32'(got), 32'(w));
        total_rises += rises;
        total_strobes += strobes;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        ena = 1'b1;
        bus.data = 8'h5A;
        bus.latch = 1'b1;
        bus.valid = 1'b1;
        bus2.data = 1'b0;
        bus2.latch = 1'b0;
        bus2.valid = 1'b0;

        // 1. Reset held with valid high: all outputs low, nothing accepted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset c%0d {din,dclk,strobe,busy,ready}", i),
                  32'({din, dclk, strobe, busy, bus.ready}), 32'd0);
        end
        bus.valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("reset release ready", 32'(bus.ready), 32'd1);
        check("reset release busy", 32'(busy), 32'd0);
        tick();

        // 2. Single word 0xA5 with strobe: strobe cycles 33-34, ready at 35.
        total_strobes = 0;
        xfer("a5_latch", 8'hA5, 1'b1, 0, 0, 1'b0);
        check("a5_latch strobe_cycles", 32'(total_strobes), 32'(DV));
        tick();

        // 3. Back-to-back 0xFF then 0x01 without strobe.
        total_rises = 0;
        total_strobes = 0;
        xfer("ff_b2b", 8'hFF, 1'b0, 0, 0, 1'b1);
        xfer("01_b2b", 8'h01, 1'b0, 0, 0, 1'b0);
        check("b2b total_rises", 32'(total_rises), 32'd16);
        check("b2b strobe_cycles", 32'(total_strobes), 32'd0);
        tick();

        // 4. ena low for cycles 10-14 of a 0x3C transfer; strobe at 38-39.
        xfer("3c_stall", 8'h3C, 1'b1, 10, 5, 1'b0);
        tick();

        // 5. Reset at cycle 12 of a 0x81 transfer, then a clean 0x42.
        bus.data = 8'h81;
        bus.latch = 1'b1;
        bus.valid = 1'b1;
        #1;
        tick();
        bus.valid = 1'b0;
        repeat (11) tick();
        check("midreset busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset {din,dclk,strobe,busy,ready}",
              32'({din, dclk, strobe, busy, bus.ready}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (strobe || busy || dclk || din) bad++;
        end
        check("midreset no_activity_after", 32'(bad), 32'd0);
        xfer("42_after_reset", 8'h42, 1'b1, 0, 0, 1'b0);
        tick();

        // 6. DIV=1, DATA_W=1 corner: din 1 / dclk / strobe / ready on 1..4.
        bus2.data = 1'b1;
        bus2.latch = 1'b1;
        bus2.valid = 1'b1;
        #1;
        check("div1 accept_ready", 32'(bus2.ready), 32'd1);
        tick();
        bus2.valid = 1'b0;
        check("div1 c1 {din,dclk,strobe,busy,ready}",
              32'({din2, dclk2, strobe2, busy2, bus2.ready}), 32'b10010);
        tick();
        check("div1 c2 {din,dclk,strobe,busy,ready}",
              32'({din2, dclk2, strobe2, busy2, bus2.ready}), 32'b11010);
        tick();
        check("div1 c3 {din,dclk,strobe,busy,ready}",
              32'({din2, dclk2, strobe2, busy2, bus2.ready}), 32'b00110);
        tick();
        check("div1 c4 {din,dclk,strobe,busy,ready}",
              32'({din2, dclk2, strobe2, busy2, bus2.ready}), 32'b00001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
